// File: rtl/demux_1_4_16b_buf_pkg.sv
// Shared constants for the 1:4 buffered demux: lane count, select width,
// lane state encodings and drain-counter width.
package demux_1_4_16b_buf_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    localparam logic LANE_EMPTY = 1'b0;
    localparam logic LANE_FULL  = 1'b1;

endpackage

// File: rtl/demux_1_4_16b_buf_lane.sv
// One output lane: single-entry skid register with valid/ready handshake.
// Optional drain counter built only when DEMUX_1_4_STATS_EN is defined.
module demux_lane
    import demux_1_4_16b_buf_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [N-1:0]     wr_data,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] drain_cnt
);

    logic         full_q, full_d;
    logic [N-1:0] data_q, data_d;
    logic         drain;

    assign drain = (full_q == LANE_FULL) && out_ready;

    // A write in the same cycle as a drain keeps the lane full: the consumer
    // takes the old word while the register captures the new one.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain) begin
            full_d = LANE_EMPTY;
        end
        if (wr_en) begin
            full_d = LANE_FULL;
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= LANE_EMPTY;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (full_q == LANE_FULL);

`ifdef DEMUX_1_4_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drain_cnt = cnt_q;
`else
    assign drain_cnt = '0;
`endif

endmodule

// File: rtl/demux_1_4_16b_buf.sv
// 1:4 demux of a 16-bit source into four independently back-pressured lanes.
// Define DEMUX_1_4_STATS_EN to build the per-lane drain counters on LaneCnt.
module demux_1_4_16b_buf
    import demux_1_4_16b_buf_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           In,
    input  logic [SEL_W-1:0]       S,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [N-1:0]           Out0,
    output logic [N-1:0]           Out1,
    output logic [N-1:0]           Out2,
    output logic [N-1:0]           Out3,
    output logic [LANES-1:0]       OutValid,
    input  logic [LANES-1:0]       OutReady,
    output logic [LANES*CNT_W-1:0] LaneCnt
);

    logic [LANES-1:0] lane_full;
    logic [LANES-1:0] wr_en;
    logic             accept;
    logic [N-1:0]     lane_data [LANES];
    logic [CNT_W-1:0] lane_cnt  [LANES];

    // Ready only looks at the selected lane, so a stalled consumer blocks
    // just the traffic aimed at it.
    assign InReady = !lane_full[S] || OutReady[S];
    assign accept  = InValid && InReady;

    always_comb begin
        wr_en    = '0;
        wr_en[S] = accept;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(.N(N)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en[i]),
            .wr_data   (In),
            .out_ready (OutReady[i]),
            .out_data  (lane_data[i]),
            .out_valid (lane_full[i]),
            .drain_cnt (lane_cnt[i])
        );
        assign LaneCnt[CNT_W*i +: CNT_W] = lane_cnt[i];
    end

    assign OutValid = lane_full;
    assign Out0     = lane_data[0];
    assign Out1     = lane_data[1];
    assign Out2     = lane_data[2];
    assign Out3     = lane_data[3];

endmodule

// File: tb/tb_demux_1_4_16b_buf.sv
// Table-driven bench for demux_1_4_16b_buf with a per-lane data scoreboard.
module tb_demux_1_4_16b_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] In;
    logic [1:0]  S;
    logic        InValid;
    logic        InReady;
    logic [15:0] Out0, Out1, Out2, Out3;
    logic [3:0]  OutValid;
    logic [3:0]  OutReady;
    logic [31:0] LaneCnt;

    demux_1_4_16b_buf #(.N(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .In       (In),
        .S        (S),
        .InValid  (InValid),
        .InReady  (InReady),
        .Out0     (Out0),
        .Out1     (Out1),
        .Out2     (Out2),
        .Out3     (Out3),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .LaneCnt  (LaneCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        iv;
        logic [1:0]  s;
        logic [15:0] din;
        logic [3:0]  ordy;
        logic        exp_irdy;
        logic [3:0]  exp_ov;
    } vec_t;

    vec_t        tbl [22];
    logic [15:0] out_w [4];
    logic [15:0] sbq [4][$];
    logic [7:0]  mcnt [4];
    int          n_checks = 0;
    int          n_fail = 0;

    assign out_w[0] = Out0;
    assign out_w[1] = Out1;
    assign out_w[2] = Out2;
    assign out_w[3] = Out3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef DEMUX_1_4_STATS_EN
        return {mcnt[3], mcnt[2], mcnt[1], mcnt[0]};
`else
        return 32'h0;
`endif
    endfunction

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input vec_t v);
        rst      = v.rstn;
        InValid  = v.iv;
        S        = v.s;
        In       = v.din;
        OutReady = v.ordy;
        #1;
        chk("in_ready", 32'(InReady), 32'(v.exp_irdy));
        if (!v.rstn) begin
            for (int l = 0; l < 4; l++) begin
                sbq[l].delete();
                mcnt[l] = 8'h0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (OutValid[l]) begin
                    if (sbq[l].size() == 0) begin
                        chk($sformatf("spurious_valid_lane%0d", l), 32'(OutValid[l]), 32'h0);
                    end else begin
                        chk($sformatf("lane%0d_data", l), 32'(out_w[l]), 32'(sbq[l][0]));
                        if (OutReady[l]) begin
                            void'(sbq[l].pop_front());
                            mcnt[l] = mcnt[l] + 8'h1;
                        end
                    end
                end
            end
            if (v.iv && v.exp_irdy) sbq[v.s].push_back(v.din);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(OutValid), 32'(v.exp_ov));
        chk("lane_cnt", LaneCnt, exp_cnt());
        @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(tbl[i]);
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        chk({tag, "_out0"}, 32'(Out0), 32'(e0));
        chk({tag, "_out1"}, 32'(Out1), 32'(e1));
        chk({tag, "_out2"}, 32'(Out2), 32'(e2));
        chk({tag, "_out3"}, 32'(Out3), 32'(e3));
    endtask

    initial begin
        vec_t v;
        //            rstn  iv    s     din       ordy     irdy  ov
        // reset held two cycles with a pending write to lane 2
        tbl[0]  = '{1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0000};
        // release, then steer one word to each lane with all consumers ready
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 1'b1, 2'd0, 16'h1111, 4'b1111, 1'b1, 4'b0001};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 16'h2222, 4'b1111, 1'b1, 4'b0010};
        tbl[5]  = '{1'b1, 1'b1, 2'd2, 16'h3333, 4'b1111, 1'b1, 4'b0100};
        tbl[6]  = '{1'b1, 1'b1, 2'd3, 16'h4444, 4'b1111, 1'b1, 4'b1000};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000};
        // lane 1 stalled; lane 3 keeps flowing; 5A5A held until lane 1 drains
        tbl[8]  = '{1'b1, 1'b1, 2'd1, 16'hA5A5, 4'b1101, 1'b1, 4'b0010};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 16'h0000, 4'b1101, 1'b0, 4'b0010};
        tbl[10] = '{1'b1, 1'b1, 2'd3, 16'h0F0F, 4'b1101, 1'b1, 4'b1010};
        tbl[11] = '{1'b1, 1'b1, 2'd1, 16'h5A5A, 4'b1101, 1'b0, 4'b0010};
        tbl[12] = '{1'b1, 1'b1, 2'd1, 16'h5A5A, 4'b1111, 1'b1, 4'b0010};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000};
        // same-cycle fill and drain on lane 2
        tbl[14] = '{1'b1, 1'b1, 2'd2, 16'h0001, 4'b0000, 1'b1, 4'b0100};
        tbl[15] = '{1'b1, 1'b1, 2'd2, 16'h0002, 4'b0100, 1'b1, 4'b0100};
        tbl[16] = '{1'b1, 1'b0, 2'd2, 16'h0000, 4'b0000, 1'b0, 4'b0100};
        tbl[17] = '{1'b1, 1'b0, 2'd2, 16'h0000, 4'b0100, 1'b1, 4'b0000};
        // lanes 0 and 3 full, then a one-cycle reset
        tbl[18] = '{1'b1, 1'b1, 2'd0, 16'hC0C0, 4'b0000, 1'b1, 4'b0001};
        tbl[19] = '{1'b1, 1'b1, 2'd3, 16'hD3D3, 4'b0000, 1'b1, 4'b1001};
        tbl[20] = '{1'b0, 1'b1, 2'd1, 16'hEEEE, 4'b1111, 1'b1, 4'b0000};
        tbl[21] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000};

        for (int l = 0; l < 4; l++) mcnt[l] = 8'h0;
        rst = 1'b0; InValid = 1'b0; S = 2'd0; In = 16'h0; OutReady = 4'h0;
        @(posedge clk);
        @(negedge clk);

        run_rows(0, 1);
        chk_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        run_rows(2, 17);
        chk_outs("hold", 16'h1111, 16'h5A5A, 16'h0002, 16'h0F0F);
        run_rows(18, 21);
        chk_outs("midreset", 16'h0, 16'h0, 16'h0, 16'h0);

        // Back-to-back traffic on lane 0: 257 drains in total.
        for (int k = 0; k < 257; k++) begin
            v = '{1'b1, 1'b1, 2'd0, 16'(k), 4'b0001, 1'b1, 4'b0001};
            step(v);
        end
        v = '{1'b1, 1'b0, 2'd0, 16'h0, 4'b0001, 1'b1, 4'b0000};
        step(v);
`ifdef DEMUX_1_4_STATS_EN
        chk("lane0_cnt_wrap", 32'(LaneCnt[7:0]), 32'h01);
`else
        chk("lanecnt_off", LaneCnt, 32'h0);
`endif
        chk("lane0_last", 32'(Out0), 32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
